// File: rtl/pb_pkg.sv
// Shared pushbutton definitions: event-FSM state encoding and default thresholds
// also used by the debounce and control blocks.
package pb_pkg;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      IDLE     = 2'd1,
      PRESSED  = 2'd2,
      LONG     = 2'd3
   } pb_state_e;

   localparam int unsigned PB_CNT_W      = 8;
   localparam int unsigned PB_LONG_CNT   = 8;
   localparam int unsigned PB_REPEAT_CNT = 4;

endpackage

// File: rtl/pb_hold_counter.sv
// Saturating hold counter with synchronous clear and a run-time terminal compare.
// Ports:
//   clk_d  in   debounce-domain clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear (wins over inc)
//   inc    in   saturating increment
//   limit  in   terminal value to compare against
//   hit_c  out  combinational, 1 when count equals limit
module pb_hold_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_d,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic             hit_c
);

   logic [CNT_W-1:0] cnt;

   // Count up, stick at all-ones so a long hold never wraps back to a threshold.
   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign hit_c = (cnt == limit);

endmodule

// File: rtl/pb_event_gen.sv
// Turns the debounced button level into single-cycle press / release / click /
// long-press events, with optional auto-repeat while long-held.
// Build option: define PB_AUTO_REPEAT_EN to enable repeat_pulse generation;
// otherwise repeat_pulse stays 0 and the counter stops once in LONG.
// Ports:
//   clk_d          in   debounce-domain clock
//   rst_n          in   asynchronous active-low reset
//   pb_de          in   debounced button level, 1 = pressed
//   press_pulse    out  one-cycle pulse on accepted press
//   release_pulse  out  one-cycle pulse on any release
//   click_pulse    out  one-cycle pulse on release before the long threshold
//   long_pulse     out  one-cycle pulse when the hold reaches LONG_CNT
//   repeat_pulse   out  periodic one-cycle pulse while long-held
//   held           out  level, 1 while PRESSED or LONG
module pb_event_gen
   import pb_pkg::*;
#(
   parameter int unsigned CNT_W      = PB_CNT_W,
   parameter int unsigned LONG_CNT   = PB_LONG_CNT,
   parameter int unsigned REPEAT_CNT = PB_REPEAT_CNT
) (
   input  logic clk_d,
   input  logic rst_n,
   input  logic pb_de,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   pb_state_e        state, state_nx;
   logic             press_nx, release_nx, click_nx, long_nx, repeat_nx, held_nx;
   logic             cnt_clr, cnt_inc, cnt_hit_c;
   logic [CNT_W-1:0] cnt_limit;

   // One counter serves both thresholds; the compare limit follows the state.
   pb_hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
      .clk_d (clk_d),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .limit (cnt_limit),
      .hit_c (cnt_hit_c)
   );

   // State and registered event outputs.
   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
         state         <= WAIT_REL;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         state         <= state_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         click_pulse   <= click_nx;
         long_pulse    <= long_nx;
         repeat_pulse  <= repeat_nx;
         held          <= held_nx;
      end
   end

   // Next state, next outputs and counter control. Release always takes priority
   // over a threshold hit in the same cycle.
   always_comb begin
      state_nx   = state;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      click_nx   = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      cnt_limit  = CNT_W'(LONG_CNT - 1);

      case (state)
         WAIT_REL: begin
            if (!pb_de) state_nx = IDLE;
         end
         IDLE: begin
            if (pb_de) begin
               state_nx = PRESSED;
               press_nx = 1'b1;
            end
         end
         PRESSED: begin
            if (!pb_de) begin
               state_nx   = IDLE;
               release_nx = 1'b1;
               click_nx   = 1'b1;
            end else if (cnt_hit_c) begin
               state_nx = LONG;
               long_nx  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         LONG: begin
            cnt_limit = CNT_W'(REPEAT_CNT - 1);
            if (!pb_de) begin
               state_nx   = IDLE;
               release_nx = 1'b1;
            end else begin
`ifdef PB_AUTO_REPEAT_EN
               if (cnt_hit_c) begin
                  repeat_nx = 1'b1;
                  cnt_clr   = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
`endif
            end
         end
         default: state_nx = WAIT_REL;
      endcase

      // Every state change restarts the hold count; idle states keep it cleared.
      if ((state_nx != state) || (state == IDLE) || (state == WAIT_REL)) cnt_clr = 1'b1;

      held_nx = (state_nx == PRESSED) || (state_nx == LONG);
   end

endmodule

// File: tb/tb_pb_event_gen.sv
// Directed bench for pb_event_gen (LONG_CNT=8, REPEAT_CNT=4). Inputs change on the
// falling edge; outputs are checked on the following falling edge.
module tb_pb_event_gen;

   logic clk_d;
   logic rst_n;
   logic pb_de;
   logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

   pb_event_gen #(.CNT_W(8), .LONG_CNT(8), .REPEAT_CNT(4)) dut (
      .clk_d         (clk_d),
      .rst_n         (rst_n),
      .pb_de         (pb_de),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .click_pulse   (click_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .held          (held)
   );

   initial clk_d = 1'b0;
   always #5 clk_d = ~clk_d;

   // Output vector order: {press, release, click, long, repeat, held}
   localparam logic [5:0] O_NONE  = 6'b000000;
   localparam logic [5:0] O_PRESS = 6'b100000;
   localparam logic [5:0] O_REL   = 6'b010000;
   localparam logic [5:0] O_CLICK = 6'b001000;
   localparam logic [5:0] O_LONG  = 6'b000100;
   localparam logic [5:0] O_REP   = 6'b000010;
   localparam logic [5:0] O_HELD  = 6'b000001;
`ifdef PB_AUTO_REPEAT_EN
   localparam logic [5:0] O_REPX  = O_REP;
`else
   localparam logic [5:0] O_REPX  = O_NONE;
`endif

   typedef struct {
      logic       pb;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic logic [5:0] outs();
      return {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};
   endfunction

   task automatic check(input string nm, input int idx, input logic [5:0] exp);
      logic [5:0] got;
      got = outs();
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] t=%0t got=%b expected=%b (press,rel,click,long,rep,held)",
                  nm, idx, $time, got, exp);
      end
   endtask

   task automatic add(input logic pb, input logic [5:0] exp);
      vec_t v;
      v.pb  = pb;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic step(input string nm, input int idx, input logic pb, input logic [5:0] exp);
      pb_de = pb;
      @(negedge clk_d);
      check(nm, idx, exp);
   endtask

   initial begin
      // Idle after reset, press raised at cycle 5.
      for (int i = 0; i < 4; i++) add(1'b0, O_NONE);
      add(1'b1, O_PRESS | O_HELD);
      // Short press: release gives release+click together.
      add(1'b1, O_HELD);
      add(1'b1, O_HELD);
      add(1'b0, O_REL | O_CLICK);
      add(1'b0, O_NONE);
      // Immediate release after press.
      add(1'b1, O_PRESS | O_HELD);
      add(1'b0, O_REL | O_CLICK);
      // Release on the very cycle the long threshold would be hit: click, no long.
      add(1'b1, O_PRESS | O_HELD);
      for (int i = 0; i < 7; i++) add(1'b1, O_HELD);
      add(1'b0, O_REL | O_CLICK);
      add(1'b0, O_NONE);
      // Long hold: long 8 cycles after press, repeats every 4 cycles after that.
      add(1'b1, O_PRESS | O_HELD);
      for (int i = 0; i < 7; i++) add(1'b1, O_HELD);
      add(1'b1, O_LONG | O_HELD);
      for (int k = 1; k <= 13; k++) add(1'b1, ((k % 4) == 0) ? (O_REPX | O_HELD) : O_HELD);
      add(1'b0, O_REL);
      add(1'b0, O_NONE);

      // Reset with button released.
      rst_n = 1'b0;
      pb_de = 1'b0;
      repeat (2) @(negedge clk_d);
      check("reset", 0, O_NONE);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         pb_de = vecs[i].pb;
         @(negedge clk_d);
         check("vec", i, vecs[i].exp);
      end

      // Button held through reset release: no press until released and pressed again.
      pb_de = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk_d);
      check("hold_rst", 0, O_NONE);
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) step("hold_rst", i, 1'b1, O_NONE);
      step("hold_rst", 6, 1'b0, O_NONE);
      step("hold_rst", 7, 1'b1, O_PRESS | O_HELD);
      step("hold_rst", 8, 1'b0, O_REL | O_CLICK);

      // Reset asserted mid-LONG: outputs drop without a clock, release gives no pulse.
      step("long_rst", 0, 1'b1, O_PRESS | O_HELD);
      for (int i = 1; i <= 7; i++) step("long_rst", i, 1'b1, O_HELD);
      step("long_rst", 8, 1'b1, O_LONG | O_HELD);
      step("long_rst", 9, 1'b1, O_HELD);
      step("long_rst", 10, 1'b1, O_HELD);
      #2 rst_n = 1'b0;
      #1 check("long_rst_async", 0, O_NONE);
      pb_de = 1'b0;
      @(negedge clk_d);
      check("long_rst_async", 1, O_NONE);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step("long_rst_rel", i, 1'b0, O_NONE);
      step("long_rst_rel", 3, 1'b1, O_PRESS | O_HELD);
      step("long_rst_rel", 4, 1'b0, O_REL | O_CLICK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
